// File: rtl/frame_dump_tx_pkg.sv
// rtl/frame_dump_tx_pkg.sv - shared state encoding and header constants for frame_dump_tx
package frame_dump_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    FETCH,
    LATCH,
    SEND,
    CSUM,
    DONE
  } state_t;

  localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;
  localparam int         HDR_LEN       = 4;

endpackage

// File: rtl/frame_dump_tx_btn_debounce.sv
// rtl/frame_dump_tx_btn_debounce.sv - button synchroniser, stability filter and press trigger
module frame_dump_tx_btn_debounce #(
  parameter int DEBOUNCE_BITS = 14
) (
  input  logic sys_clk_i,
  input  logic sys_rst_n_i,
  input  logic btn_i,
  output logic trig_o
);

  logic                     sync0;
  logic                     sync1;
  logic                     stable;
  logic [DEBOUNCE_BITS-1:0] cnt;
  logic                     cnt_sat;

  assign cnt_sat = &cnt;

  // The counter measures how long the synced level has been steady; sync1 only
  // changes after a cycle with sync0 != sync1, so every edge restarts the window.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      trig_o <= 1'b0;
    end else begin
      sync0 <= btn_i;
      sync1 <= sync0;
      if (sync0 != sync1) begin
        cnt <= '0;
      end else if (!cnt_sat) begin
        cnt <= cnt + 1'b1;
      end
      if (cnt_sat) begin
        stable <= sync1;
      end
      trig_o <= cnt_sat & sync1 & ~stable;
    end
  end

endmodule

// File: rtl/frame_dump_tx.sv
// rtl/frame_dump_tx.sv - dumps the downsample buffer over the UART with header and checksum
module frame_dump_tx
  import frame_dump_tx_pkg::*;
#(
  parameter int         X_COUNT       = 40,
  parameter int         Y_COUNT       = 30,
  parameter int         DEBOUNCE_BITS = 14,
  parameter int         HOLDOFF_BITS  = 13,
  parameter logic [7:0] SYNC0         = SYNC0_DEFAULT,
  parameter logic [7:0] SYNC1         = SYNC1_DEFAULT
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic        btn_i,
  output logic [5:0]  read_x,
  output logic [4:0]  read_y,
  input  logic [31:0] read_q,
  output logic [7:0]  uart_dat_o,
  output logic        uart_wr_o,
  input  logic        uart_busy_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [5:0] X_LAST   = 6'(X_COUNT - 1);
  localparam logic [4:0] Y_LAST   = 5'(Y_COUNT - 1);
  localparam logic [1:0] HDR_LAST = 2'(HDR_LEN - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic                    trig;
  logic [HOLDOFF_BITS-1:0] hold_cnt;
  logic                    tx_ready;
  logic [1:0]              byte_idx;
  logic [31:0]             word_q;
  logic [7:0]              csum_q;
  logic                    last_word;
  logic                    send;
  logic [7:0]              tx_byte;

  frame_dump_tx_btn_debounce #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_btn_debounce (
    .sys_clk_i  (sys_clk_i),
    .sys_rst_n_i(sys_rst_n_i),
    .btn_i      (btn_i),
    .trig_o     (trig)
  );

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i || uart_busy_i) begin
      hold_cnt <= '0;
    end else if (!(&hold_cnt)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // The pending strobe blocks a second write before the UART has raised busy.
  assign tx_ready  = (&hold_cnt) & ~uart_busy_i & ~uart_wr_o;
  assign last_word = (read_x == X_LAST) && (read_y == Y_LAST);

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trig) state_d = HDR;
      HDR:     if (tx_ready && byte_idx == HDR_LAST) state_d = FETCH;
      FETCH:   state_d = LATCH;
      LATCH:   state_d = SEND;
      SEND:    if (tx_ready && byte_idx == 2'd3) state_d = last_word ? CSUM : FETCH;
      CSUM:    if (tx_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    send    = 1'b0;
    tx_byte = 8'h00;
    case (state_q)
      HDR: begin
        send = tx_ready;
        case (byte_idx)
          2'd0:    tx_byte = SYNC0;
          2'd1:    tx_byte = SYNC1;
          2'd2:    tx_byte = 8'(X_COUNT);
          default: tx_byte = 8'(Y_COUNT);
        endcase
      end
      SEND: begin
        send = tx_ready;
        case (byte_idx)
          2'd0:    tx_byte = word_q[31:24];
          2'd1:    tx_byte = word_q[23:16];
          2'd2:    tx_byte = word_q[15:8];
          default: tx_byte = word_q[7:0];
        endcase
      end
      CSUM: begin
        send    = tx_ready;
        tx_byte = csum_q;
      end
      default: begin
        send    = 1'b0;
        tx_byte = 8'h00;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      read_x     <= '0;
      read_y     <= '0;
      uart_dat_o <= '0;
      uart_wr_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      byte_idx   <= '0;
      word_q     <= '0;
      csum_q     <= '0;
    end else begin
      uart_wr_o <= send;
      done_o    <= 1'b0;
      if (send) begin
        uart_dat_o <= tx_byte;
      end
      case (state_q)
        IDLE: begin
          if (trig) begin
            busy_o   <= 1'b1;
            byte_idx <= '0;
            csum_q   <= '0;
            read_x   <= '0;
            read_y   <= '0;
          end
        end
        HDR: begin
          if (send) byte_idx <= byte_idx + 1'b1;
        end
        LATCH: begin
          word_q   <= read_q;
          byte_idx <= '0;
        end
        SEND: begin
          if (send) begin
            csum_q   <= csum_q + tx_byte;
            byte_idx <= byte_idx + 1'b1;
            // The final address is held so read_x/read_y never leave the buffer.
            if (byte_idx == 2'd3 && !last_word) begin
              if (read_x == X_LAST) begin
                read_x <= '0;
                read_y <= read_y + 1'b1;
              end else begin
                read_x <= read_x + 1'b1;
              end
            end
          end
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_dump_tx.sv
// tb/tb_frame_dump_tx.sv - directed bench for frame_dump_tx (2x2 geometry and 40x30 geometry)
module tb_frame_dump_tx;

  logic        clk = 1'b0;
  logic        rst_n_s = 1'b0, btn_s = 1'b0;
  logic [5:0]  rx_s;
  logic [4:0]  ry_s;
  logic [31:0] rq_s = '0;
  logic [7:0]  dat_s;
  logic        wr_s, ubusy_s, busy_s, done_s;

  logic        rst_n_b = 1'b0, btn_b = 1'b0;
  logic [5:0]  rx_b;
  logic [4:0]  ry_b;
  logic [31:0] rq_b = '0;
  logic [7:0]  dat_b;
  logic        wr_b, busy_b, done_b;
  logic        ubusy_b = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_dump_tx #(
    .X_COUNT(2), .Y_COUNT(2), .DEBOUNCE_BITS(3), .HOLDOFF_BITS(2)
  ) dut_s (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n_s), .btn_i(btn_s),
    .read_x(rx_s), .read_y(ry_s), .read_q(rq_s),
    .uart_dat_o(dat_s), .uart_wr_o(wr_s), .uart_busy_i(ubusy_s),
    .busy_o(busy_s), .done_o(done_s)
  );

  frame_dump_tx #(
    .DEBOUNCE_BITS(4)
  ) dut_b (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n_b), .btn_i(btn_b),
    .read_x(rx_b), .read_y(ry_b), .read_q(rq_b),
    .uart_dat_o(dat_b), .uart_wr_o(wr_b), .uart_busy_i(ubusy_b),
    .busy_o(busy_b), .done_o(done_b)
  );

  // Buffer models: 1-cycle read latency.
  always @(posedge clk) begin
    rq_s <= {5'd0, ry_s, rx_s, 8'h00, 8'h11};
    rq_b <= {5'd0, ry_b, rx_b, 8'h00, 8'h11};
  end

  // UART model for the small instance: busy for 10 cycles after each strobe.
  int ucnt = 0;
  always @(posedge clk) begin
    if (wr_s) ucnt <= 10;
    else if (ucnt != 0) ucnt <= ucnt - 1;
  end
  assign ubusy_s = (ucnt != 0);

  logic [7:0] q_s[$];
  int  done_cnt_s = 0, done_busy_bad = 0, strobe_while_busy = 0, oob_s = 0;
  int  cyc = 0, fall_cyc = -1, min_gap = 1000;
  logic prev_ubusy = 1'b0, prev_busy_s = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (prev_ubusy && !ubusy_s) fall_cyc = cyc;
    prev_ubusy = ubusy_s;
    if (wr_s) begin
      q_s.push_back(dat_s);
      if (ubusy_s) strobe_while_busy++;
      if (fall_cyc >= 0) begin
        if (cyc - fall_cyc < min_gap) min_gap = cyc - fall_cyc;
        fall_cyc = -1;
      end
    end
    if (done_s) begin
      done_cnt_s++;
      if (busy_s !== 1'b0 || prev_busy_s !== 1'b1) done_busy_bad++;
    end
    prev_busy_s = busy_s;
    if (rx_s >= 6'd2 || ry_s >= 5'd2) oob_s++;
  end

  int cnt_b = 0, done_cnt_b = 0, oob_b = 0;
  logic [7:0] hdr_b[4];
  logic [7:0] last_b = 8'h00;
  logic [5:0] last_rx_b = '0;
  logic [4:0] last_ry_b = '0;

  always @(negedge clk) begin
    if (wr_b) begin
      if (cnt_b < 4) hdr_b[cnt_b] = dat_b;
      cnt_b++;
      last_b = dat_b;
      if (cnt_b == 4804) begin
        last_rx_b = rx_b;
        last_ry_b = ry_b;
      end
    end
    if (done_b) done_cnt_b++;
    if (rx_b >= 6'd40 || ry_b >= 5'd30) oob_b++;
  end

  logic [7:0] exp_small[21];
  initial exp_small = '{8'hA5, 8'h5A, 8'h02, 8'h02,
                        8'h00, 8'h00, 8'h00, 8'h11,
                        8'h00, 8'h01, 8'h00, 8'h11,
                        8'h00, 8'h40, 8'h00, 8'h11,
                        8'h00, 8'h41, 8'h00, 8'h11,
                        8'hC6};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_s(input int n);
    btn_s = 1'b1;
    tick(n);
    btn_s = 1'b0;
  endtask

  task automatic wait_done_s(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt_s >= target) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic clear_s();
    q_s.delete();
    done_cnt_s = 0;
  endtask

  task automatic test_reset();
    rst_n_s = 1'b0;
    rst_n_b = 1'b0;
    tick(3);
    rst_n_s = 1'b1;
    rst_n_b = 1'b1;
    checks++; if (wr_s !== 1'b0) begin errors++; $display("FAIL reset_wr got %0b want 0", wr_s); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_s); end
    checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done_s); end
    checks++; if (dat_s !== 8'h00) begin errors++; $display("FAIL reset_dat got %h want 00", dat_s); end
    checks++; if (rx_s !== 6'd0 || ry_s !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d,%0d want 0,0", rx_s, ry_s); end
    tick(20);
  endtask

  task automatic test_single_dump();
    bit ok;
    clear_s();
    press_s(20);
    wait_done_s(1, 2000, ok);
    tick(30);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got no done_o want done_o"); end
    checks++; if (q_s.size() != 21) begin errors++; $display("FAIL single_count got %0d want 21", q_s.size()); end
    for (int i = 0; i < 21; i++) begin
      checks++;
      if (i >= q_s.size() || q_s[i] !== exp_small[i]) begin
        errors++;
        $display("FAIL single_byte%0d got %h want %h", i, (i < q_s.size()) ? q_s[i] : 8'hxx, exp_small[i]);
      end
    end
    checks++; if (done_cnt_s != 1) begin errors++; $display("FAIL single_done_pulses got %0d want 1", done_cnt_s); end
    checks++; if (done_busy_bad != 0) begin errors++; $display("FAIL single_busy_fall got %0d bad want 0", done_busy_bad); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL single_busy_after got %0b want 0", busy_s); end
  endtask

  task automatic test_glitch();
    bit busy_seen = 1'b0;
    clear_s();
    btn_s = 1'b1;
    tick(3);
    btn_s = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (busy_s) busy_seen = 1'b1;
    end
    checks++; if (q_s.size() != 0) begin errors++; $display("FAIL glitch_strobes got %0d want 0", q_s.size()); end
    checks++; if (busy_seen) begin errors++; $display("FAIL glitch_busy got 1 want 0"); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_s();
    press_s(20);
    tick(60);
    checks++; if (busy_s !== 1'b1) begin errors++; $display("FAIL b2b_busy_mid got %0b want 1", busy_s); end
    press_s(20);
    wait_done_s(1, 2000, ok);
    tick(300);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got no done_o want done_o"); end
    checks++; if (q_s.size() != 21) begin errors++; $display("FAIL b2b_count got %0d want 21", q_s.size()); end
    checks++; if (done_cnt_s != 1) begin errors++; $display("FAIL b2b_done_pulses got %0d want 1", done_cnt_s); end
    clear_s();
    press_s(20);
    wait_done_s(1, 2000, ok);
    tick(30);
    checks++; if (q_s.size() != 21) begin errors++; $display("FAIL fresh_count got %0d want 21", q_s.size()); end
    checks++; if (q_s.size() == 0 || q_s[0] !== 8'hA5) begin errors++; $display("FAIL fresh_first got %h want a5", (q_s.size() > 0) ? q_s[0] : 8'hxx); end
    checks++; if (q_s.size() != 21 || q_s[20] !== 8'hC6) begin errors++; $display("FAIL fresh_csum got %h want c6", (q_s.size() > 0) ? q_s[q_s.size()-1] : 8'hxx); end
  endtask

  task automatic test_gap();
    checks++; if (min_gap < 4 || min_gap == 1000) begin errors++; $display("FAIL gap_min got %0d want >=4", min_gap); end
    checks++; if (strobe_while_busy != 0) begin errors++; $display("FAIL gap_strobe_busy got %0d want 0", strobe_while_busy); end
    checks++; if (oob_s != 0) begin errors++; $display("FAIL small_addr_range got %0d want 0", oob_s); end
  endtask

  task automatic test_reset_mid_dump();
    bit ok = 1'b0;
    int held;
    clear_s();
    press_s(20);
    for (int i = 0; i < 2000; i++) begin
      if (q_s.size() >= 7) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_reach got %0d bytes want 7", q_s.size()); end
    rst_n_s = 1'b0;
    tick(1);
    rst_n_s = 1'b1;
    checks++; if (wr_s !== 1'b0 || busy_s !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl got wr=%0b busy=%0b want 0 0", wr_s, busy_s); end
    checks++; if (rx_s !== 6'd0 || ry_s !== 5'd0) begin errors++; $display("FAIL rst_mid_addr got %0d,%0d want 0,0", rx_s, ry_s); end
    held = q_s.size();
    tick(200);
    checks++; if (q_s.size() != 7 || held != 7) begin errors++; $display("FAIL rst_mid_quiet got %0d want 7", q_s.size()); end
    done_cnt_s = 0;
    press_s(20);
    wait_done_s(1, 2000, ok);
    tick(30);
    checks++; if (q_s.size() != 28) begin errors++; $display("FAIL rst_mid_redump got %0d want 28", q_s.size()); end
    checks++; if (q_s.size() < 8 || q_s[7] !== 8'hA5) begin errors++; $display("FAIL rst_mid_restart got %h want a5", (q_s.size() > 7) ? q_s[7] : 8'hxx); end
  endtask

  task automatic test_defaults();
    bit ok = 1'b0;
    int sum = 0;
    for (int y = 0; y < 30; y++) begin
      for (int x = 0; x < 40; x++) begin
        sum += (y >> 2) + (((y & 3) << 6) | x) + 8'h11;
      end
    end
    btn_b = 1'b1;
    tick(40);
    btn_b = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      if (done_cnt_b >= 1) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    tick(20);
    checks++; if (!ok) begin errors++; $display("FAIL dflt_timeout got no done_o want done_o"); end
    checks++; if (cnt_b != 4805) begin errors++; $display("FAIL dflt_count got %0d want 4805", cnt_b); end
    checks++; if (hdr_b[0] !== 8'hA5 || hdr_b[1] !== 8'h5A) begin errors++; $display("FAIL dflt_sync got %h %h want a5 5a", hdr_b[0], hdr_b[1]); end
    checks++; if (hdr_b[2] !== 8'h28 || hdr_b[3] !== 8'h1E) begin errors++; $display("FAIL dflt_dims got %h %h want 28 1e", hdr_b[2], hdr_b[3]); end
    checks++; if (last_rx_b !== 6'd39 || last_ry_b !== 5'd29) begin errors++; $display("FAIL dflt_last_addr got %0d,%0d want 39,29", last_rx_b, last_ry_b); end
    checks++; if (last_b !== 8'(sum)) begin errors++; $display("FAIL dflt_csum got %h want %h", last_b, 8'(sum)); end
    checks++; if (done_cnt_b != 1 || busy_b !== 1'b0) begin errors++; $display("FAIL dflt_done got %0d busy=%0b want 1 0", done_cnt_b, busy_b); end
    checks++; if (oob_b != 0) begin errors++; $display("FAIL dflt_addr_range got %0d want 0", oob_b); end
  endtask

  initial begin
    test_reset();
    test_single_dump();
    test_glitch();
    test_back_to_back();
    test_gap();
    test_reset_mid_dump();
    test_defaults();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
